// File: rtl/uut_job_sched.sv
// Two-requester job scheduler: arbitrates round-robin, programs a CSR-mapped burst engine,
// polls its status until idle, error or poll timeout, then reports completion.
module uut_job_sched #(
    parameter logic [4:0] CTRL_ADDR = 5'd0,
    parameter logic [4:0] BASE_ADDR = 5'd1,
    parameter logic [4:0] STAT_ADDR = 5'd2,
    parameter int         TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_rnw,
    input  logic [11:0] req0_length,
    input  logic [31:0] req0_addr,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_rnw,
    input  logic [11:0] req1_length,
    input  logic [31:0] req1_addr,
    output logic        done_valid,
    output logic        done_id,
    output logic        done_err,
    output logic [4:0]  avm_csr_address,
    output logic        avm_csr_write,
    output logic        avm_csr_read,
    output logic [31:0] avm_csr_writedata,
    input  logic [31:0] avm_csr_readdata
);
    localparam int             CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TO = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, WR_BASE, WR_CTRL, POLL, POLL_WAIT, CLR_ERR, DONE
    } state_t;

    state_t         state, state_nxt;
    logic           job_rnw, job_id, job_err, last_grant;
    logic [11:0]    job_len;
    logic [31:0]    job_addr;
    logic [CW-1:0]  poll_cnt;
    logic           accept, grant_id, err_set;
    logic           sel_rnw;
    logic [11:0]    sel_len;
    logic [31:0]    sel_addr;
    logic           unused_rd;

    assign unused_rd = ^avm_csr_readdata[31:2];

    assign sel_rnw  = grant_id ? req1_rnw    : req0_rnw;
    assign sel_len  = grant_id ? req1_length : req0_length;
    assign sel_addr = grant_id ? req1_addr   : req0_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            job_rnw    <= 1'b0;
            job_id     <= 1'b0;
            job_err    <= 1'b0;
            job_len    <= '0;
            job_addr   <= '0;
            last_grant <= 1'b1;
            poll_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                job_rnw    <= sel_rnw;
                job_id     <= grant_id;
                job_len    <= sel_len;
                job_addr   <= sel_addr;
                job_err    <= (sel_len == 12'd0);
                last_grant <= grant_id;
                poll_cnt   <= '0;
            end else begin
                // saturating: the timeout compare relies on the count never wrapping
                if (state == POLL && poll_cnt != TO)
                    poll_cnt <= poll_cnt + 1'b1;
                if (err_set)
                    job_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt         = state;
        accept            = 1'b0;
        grant_id          = 1'b0;
        err_set           = 1'b0;
        req0_ready        = 1'b0;
        req1_ready        = 1'b0;
        done_valid        = 1'b0;
        done_id           = 1'b0;
        done_err          = 1'b0;
        avm_csr_address   = '0;
        avm_csr_write     = 1'b0;
        avm_csr_read      = 1'b0;
        avm_csr_writedata = '0;
        case (state)
            IDLE: begin
                if (rst_n && (req0_valid || req1_valid)) begin
                    accept     = 1'b1;
                    grant_id   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    state_nxt  = (sel_len == 12'd0) ? DONE : WR_BASE;
                end
            end
            WR_BASE: begin
                avm_csr_write     = 1'b1;
                avm_csr_address   = BASE_ADDR;
                avm_csr_writedata = job_addr;
                state_nxt         = WR_CTRL;
            end
            WR_CTRL: begin
                avm_csr_write     = 1'b1;
                avm_csr_address   = CTRL_ADDR;
                avm_csr_writedata = {17'd0, 1'b0, job_rnw, ~job_rnw, job_len};
                state_nxt         = POLL;
            end
            POLL: begin
                avm_csr_read    = 1'b1;
                avm_csr_address = STAT_ADDR;
                state_nxt       = POLL_WAIT;
            end
            POLL_WAIT: begin
                if (avm_csr_readdata[1]) begin
                    err_set   = 1'b1;
                    state_nxt = CLR_ERR;
                end else if (!avm_csr_readdata[0]) begin
                    state_nxt = DONE;
                end else if (poll_cnt == TO) begin
                    err_set   = 1'b1;
                    state_nxt = CLR_ERR;
                end else begin
                    state_nxt = POLL;
                end
            end
            CLR_ERR: begin
                avm_csr_write     = 1'b1;
                avm_csr_address   = CTRL_ADDR;
                avm_csr_writedata = 32'h0000_4000;
                state_nxt         = DONE;
            end
            DONE: begin
                done_valid = 1'b1;
                done_id    = job_id;
                done_err   = job_err;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uut_job_sched.sv
// Directed self-checking bench for uut_job_sched with a scripted CSR status slave.
module tb_uut_job_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 0, req1_valid = 0, req0_rnw = 0, req1_rnw = 0;
    logic        req0_ready, req1_ready;
    logic [11:0] req0_length = '0, req1_length = '0;
    logic [31:0] req0_addr = '0, req1_addr = '0;
    logic        done_valid, done_id, done_err;
    logic [4:0]  avm_csr_address;
    logic        avm_csr_write, avm_csr_read;
    logic [31:0] avm_csr_writedata;
    logic [31:0] avm_csr_readdata = '0;

    uut_job_sched #(.TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rnw(req0_rnw),
        .req0_length(req0_length), .req0_addr(req0_addr),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rnw(req1_rnw),
        .req1_length(req1_length), .req1_addr(req1_addr),
        .done_valid(done_valid), .done_id(done_id), .done_err(done_err),
        .avm_csr_address(avm_csr_address), .avm_csr_write(avm_csr_write),
        .avm_csr_read(avm_csr_read), .avm_csr_writedata(avm_csr_writedata),
        .avm_csr_readdata(avm_csr_readdata)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0;
    int busy_polls = 0, slave_rd = 0;
    logic [31:0] stat_final = '0;

    int wr_cnt, rd_cnt, done_cnt, grant_cnt, acc_cyc, done_cyc;
    logic [4:0]  wr_addr [16];
    logic [31:0] wr_data [16];
    logic        grants  [16];
    logic        last_id, last_err;
    int conflict = 0, idle_nz = 0, bad_rd_addr = 0, ready_wide = 0;
    logic prev_r0 = 0, prev_r1 = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_cnt = 0; rd_cnt = 0; grant_cnt = 0; slave_rd = 0;
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (avm_csr_read) begin
            avm_csr_readdata <= (slave_rd < busy_polls) ? 32'h1 : stat_final;
            slave_rd <= slave_rd + 1;
        end
    end

    always @(negedge clk) begin
        if (avm_csr_write && avm_csr_read) conflict++;
        if (!avm_csr_write && !avm_csr_read && (avm_csr_address != 0 || avm_csr_writedata != 0))
            idle_nz++;
        if (avm_csr_write) begin
            if (wr_cnt < 16) begin
                wr_addr[wr_cnt] = avm_csr_address;
                wr_data[wr_cnt] = avm_csr_writedata;
            end
            wr_cnt++;
        end
        if (avm_csr_read) begin
            if (avm_csr_address != 5'd2) bad_rd_addr++;
            rd_cnt++;
        end
        if (req0_ready || req1_ready) begin
            acc_cyc = cyc;
            if (grant_cnt < 16) grants[grant_cnt] = req1_ready;
            grant_cnt++;
        end
        if ((req0_ready && prev_r0) || (req1_ready && prev_r1)) ready_wide++;
        prev_r0 = req0_ready;
        prev_r1 = req1_ready;
        if (done_valid) begin
            done_cyc = cyc;
            last_id  = done_id;
            last_err = done_err;
            done_cnt++;
        end
    end

    task automatic submit(input logic id, input logic rnw, input logic [11:0] len, input logic [31:0] addr);
        int n;
        @(posedge clk); #1;
        if (id) begin req1_valid = 1; req1_rnw = rnw; req1_length = len; req1_addr = addr; end
        else    begin req0_valid = 1; req0_rnw = rnw; req0_length = len; req0_addr = addr; end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(id ? req1_ready : req0_ready) && n < 60);
        if (n >= 60) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic wait_done(input int start);
        int n = 0;
        while (done_cnt == start && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int d0, n;
        done_cnt = 0;
        clear_log();
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'(|{req0_ready, req1_ready, done_valid, done_id, done_err,
            avm_csr_address, avm_csr_write, avm_csr_read, avm_csr_writedata}), 0);
        rst_n = 1;

        // single read job, three busy polls
        clear_log(); busy_polls = 3; stat_final = 0; d0 = done_cnt;
        submit(0, 1, 12'd16, 32'h1000);
        wait_done(d0);
        chk("rd_wr_cnt", wr_cnt, 2);
        chk("rd_base_addr", wr_addr[0], 1);
        chk("rd_base_data", wr_data[0], 32'h1000);
        chk("rd_ctrl_addr", wr_addr[1], 0);
        chk("rd_ctrl_data", wr_data[1], 32'h0000_2010);
        chk("rd_polls", rd_cnt, 4);
        chk("rd_done_id", last_id, 0);
        chk("rd_done_err", last_err, 0);
        chk("rd_latency", done_cyc - acc_cyc, 11);

        // write job from requester 1, idle on first poll
        clear_log(); busy_polls = 0; stat_final = 0; d0 = done_cnt;
        submit(1, 0, 12'h0ab, 32'hdead_beec);
        wait_done(d0);
        chk("wr_ctrl_data", wr_data[1], 32'h0000_10ab);
        chk("wr_base_data", wr_data[0], 32'hdead_beec);
        chk("wr_done_id", last_id, 1);
        chk("wr_done_err", last_err, 0);
        chk("wr_latency", done_cyc - acc_cyc, 5);

        // zero length job
        clear_log(); d0 = done_cnt;
        submit(0, 1, 12'd0, 32'h2000);
        wait_done(d0);
        chk("len0_strobes", wr_cnt + rd_cnt, 0);
        chk("len0_done_err", last_err, 1);
        chk("len0_latency", done_cyc - acc_cyc, 1);

        // status error bit
        clear_log(); busy_polls = 0; stat_final = 32'h2; d0 = done_cnt;
        submit(0, 0, 12'd4, 32'h3000);
        wait_done(d0);
        chk("err_polls", rd_cnt, 1);
        chk("err_wr_cnt", wr_cnt, 3);
        chk("err_clr_addr", wr_addr[2], 0);
        chk("err_clr_data", wr_data[2], 32'h0000_4000);
        chk("err_done_err", last_err, 1);

        // poll timeout with TIMEOUT=8
        clear_log(); busy_polls = 1000; stat_final = 0; d0 = done_cnt;
        submit(1, 1, 12'd8, 32'h4000);
        wait_done(d0);
        chk("to_polls", rd_cnt, 8);
        chk("to_clr_data", wr_data[2], 32'h0000_4000);
        chk("to_done_err", last_err, 1);
        chk("to_done_id", last_id, 1);

        // both requesters contending for eight jobs
        clear_log(); busy_polls = 0; stat_final = 0;
        @(posedge clk); #1;
        req0_valid = 1; req0_rnw = 1; req0_length = 12'd2; req0_addr = 32'h100;
        req1_valid = 1; req1_rnw = 0; req1_length = 12'd3; req1_addr = 32'h200;
        n = 0;
        while (grant_cnt < 8 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("rr_timeout", 0, 1);
        req0_valid = 0; req1_valid = 0;
        d0 = done_cnt;
        wait_done(d0);
        chk("rr_grants", grant_cnt, 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("rr_grant%0d", i), grants[i], i % 2);
        chk("rr_ready_width", ready_wide, 0);

        // reset while polling
        clear_log(); busy_polls = 1000; d0 = done_cnt;
        submit(0, 1, 12'd4, 32'h500);
        n = 0;
        while (rd_cnt < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        #2 rst_n = 0;
        #1;
        chk("midrst_outputs", 32'(|{req0_ready, req1_ready, done_valid, done_id, done_err,
            avm_csr_address, avm_csr_write, avm_csr_read, avm_csr_writedata}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (12) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 0);
        clear_log(); busy_polls = 0;
        @(posedge clk); #1;
        req0_valid = 1; req1_valid = 1;
        n = 0;
        while (grant_cnt < 1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        chk("midrst_grant", grants[0], 0);
        d0 = done_cnt;
        wait_done(d0);
        chk("midrst_job_done", last_err, 0);

        chk("strobe_conflict", conflict, 0);
        chk("idle_bus_zero", idle_nz, 0);
        chk("read_addr", bad_rd_addr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uut_job_sched.md
UUT_JOB_SCHED -- requirements
Module: uut_job_sched

Interface
REQ-001 SHALL have parameter CTRL_ADDR, default 5'd0, meaning CSR word holding length[11:0], startwr bit 12, startrd bit 13, clrerr bit 14.
REQ-002 SHALL have parameter BASE_ADDR, default 5'd1, meaning CSR word holding baseaddr[31:0].
REQ-003 SHALL have parameter STAT_ADDR, default 5'd2, meaning CSR status word: busy bit 0, error bit 1.
REQ-004 SHALL have parameter TIMEOUT, default 1024, meaning maximum status polls per job.
REQ-005 SHALL have port clk, input, 1, meaning the single clock.
REQ-006 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-007 SHALL have ports req0_valid / req1_valid, input, 1, meaning job request from requester 0/1.
REQ-008 SHALL have ports req0_ready / req1_ready, output, 1, meaning job accepted this cycle.
REQ-009 SHALL have ports req0_rnw / req1_rnw, input, 1, meaning 1 = read burst, 0 = write burst.
REQ-010 SHALL have ports req0_length / req1_length, input, 12, meaning burst length in words.
REQ-011 SHALL have ports req0_addr / req1_addr, input, 32, meaning burst base address.
REQ-012 SHALL have port done_valid, output, 1, meaning one-cycle job-complete pulse.
REQ-013 SHALL have port done_id, output, 1, meaning requester of the completed job.
REQ-014 SHALL have port done_err, output, 1, meaning the completed job failed.
REQ-015 SHALL have port avm_csr_address, output, 5, meaning CSR master word address.
REQ-016 SHALL have ports avm_csr_write / avm_csr_read, output, 1, meaning CSR write/read strobes.
REQ-017 SHALL have port avm_csr_writedata, output, 32, meaning CSR write data.
REQ-018 SHALL have port avm_csr_readdata, input, 32, meaning CSR read data, valid the cycle after avm_csr_read; the slave has no waitrequest.

Function
REQ-019 SHALL implement the states IDLE, WR_BASE, WR_CTRL, POLL, POLL_WAIT, CLR_ERR and DONE.
REQ-020 SHALL, in IDLE, accept one job per cycle: with a single valid requester it takes that one; with both valid it grants the requester not granted last (round-robin, last-grant pointer reset to 1 so requester 0 wins first).
REQ-021 SHALL, on accept, assert the granted reqN_ready for that one cycle only, latch rnw/length/addr/id, and leave ready low in every other state.
REQ-022 SHALL, for an accepted job with length==0, make no CSR access, go to DONE with done_err=1.
REQ-023 SHALL, in WR_BASE, issue a one-cycle write of addr to BASE_ADDR.
REQ-024 SHALL, in WR_CTRL, issue a one-cycle write to CTRL_ADDR with length, startrd=rnw, startwr=~rnw, clrerr=0.
REQ-025 SHALL, in POLL, issue a one-cycle read of STAT_ADDR and increment the poll counter; in POLL_WAIT sample readdata the next cycle.
REQ-026 SHALL, in POLL_WAIT: error bit=1 -> CLR_ERR with err flag set; else busy=0 -> DONE, err=0; else busy=1 -> POLL.
REQ-027 SHALL, when the poll counter reaches TIMEOUT with busy still 1, go to CLR_ERR with err flag set.
REQ-028 SHALL, in CLR_ERR, write CTRL_ADDR with clrerr=1 and start bits 0, then go to DONE.
REQ-029 SHALL, in DONE, pulse done_valid for one cycle with done_id and done_err, then return to IDLE.
REQ-030 SHALL make the earliest next accept the cycle after DONE; the error-free job latency is accept -> done_valid of 5 cycles for one poll.
REQ-031 SHALL drive only one of avm_csr_write/avm_csr_read at a time; avm_csr_address and avm_csr_writedata SHALL be 0 when no strobe is active.
REQ-032 SHALL keep the poll counter wide enough for TIMEOUT, clear it on accept, and never let it wrap.
REQ-033 SHALL ignore requests that drop before being granted; no job is queued beyond the single latched one.

Reset
REQ-034 SHALL, while rst_n is low, force state IDLE, all outputs 0, poll counter 0 and last-grant 1, with reset mid-job abandoning the job without done_valid.

Verification
REQ-035 SHALL cover a single read job (req0 rnw=1, length=16, addr=0x1000) -> writes BASE=0x1000, CTRL=0x0000_2010; status busy for 3 polls, then done_valid with id=0, err=0.
REQ-036 SHALL cover both requesters valid for 4 jobs each -> grants alternate 0,1,0,1…; each ready is one cycle wide.
REQ-037 SHALL cover length=0 -> done_err=1 with zero CSR strobes.
REQ-038 SHALL cover a status read returning 0x2 -> CTRL write of 0x0000_4000, then done_err=1.
REQ-039 SHALL cover a status held at busy with TIMEOUT=8 -> exactly 8 reads, clrerr write, done_err=1.
REQ-040 SHALL cover rst_n dropped during POLL -> outputs 0 immediately, no done_valid, and the next job starts cleanly with a grant to requester 0.
